// File: rtl/cpu_pkg.sv
// Shared definitions for the phase-2 CPU control path: opcodes, IR field
// bounds, T-state enumeration and instruction classes.
package cpu_pkg;

    // Opcode values carried in ir[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Instruction register field bounds
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;
    localparam int C_HI   = 18;
    localparam int C_LO   = 0;

    // T-state sequence; HALT is terminal until reset
    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    // Execute-sequence families selected by the opcode
    typedef enum logic [3:0] {
        CLS_RTYPE   = 4'd0,
        CLS_IMM     = 4'd1,
        CLS_LDI     = 4'd2,
        CLS_LD      = 4'd3,
        CLS_ST      = 4'd4,
        CLS_MULDIV  = 4'd5,
        CLS_UNARY   = 4'd6,
        CLS_NOP     = 4'd7,
        CLS_HALT    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } iclass_t;

    // Extract the opcode field from an instruction word
    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/control_unit_instr_class.sv
// Opcode-to-class decoder; the control FSM branches on the class only.
module instr_class
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    cls
);

    // Pure lookup; anything not listed is an undefined opcode
    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL:  cls = CLS_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:        cls = CLS_IMM;
            OP_LDI:                          cls = CLS_LDI;
            OP_LD:                           cls = CLS_LD;
            OP_ST:                           cls = CLS_ST;
            OP_MUL, OP_DIV:                  cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                  cls = CLS_UNARY;
            OP_NOP:                          cls = CLS_NOP;
            OP_HALT:                         cls = CLS_HALT;
            default:                         cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencing control unit: fetch (T0..T2) followed by a
// class-specific execute sequence (T3..T7), with memory wait states.
//
// Memory handshake: in a wait state (fetch T1, ld T6, st T7) the strobe
// and the load enable stay asserted every cycle; the state advances on
// the rising edge where mem_rdy=1, so that edge both completes the
// transfer and captures the data.
module control_unit
    import cpu_pkg::*;
#(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal
);

    state_t     state_q, state_d;
    logic       run_q, run_d;
    logic [4:0] opcode;
    iclass_t    cls;
    logic       unused_ir_bits;

    // Register fields are routed by the datapath via Gra/Grb/Grc
    assign opcode         = opcode_of(ir);
    assign unused_ir_bits = ^ir[OPC_LO-1:0];

    instr_class u_instr_class (
        .opcode (opcode),
        .cls    (cls)
    );

    // Next-state: hold in T0 for the first edge after reset, then sequence
    always_comb begin
        run_d   = 1'b1;
        state_d = state_q;
        if (run_q) begin
            case (state_q)
                S_T0: state_d = S_T1;
                S_T1: state_d = mem_rdy ? S_T2 : S_T1;
                S_T2: state_d = S_T3;
                S_T3: begin
                    case (cls)
                        CLS_NOP, CLS_ILLEGAL: state_d = S_T0;
                        CLS_HALT:             state_d = S_HALT;
                        default:              state_d = S_T4;
                    endcase
                end
                S_T4: state_d = (cls == CLS_UNARY) ? S_T0 : S_T5;
                S_T5: begin
                    case (cls)
                        CLS_LD, CLS_ST, CLS_MULDIV: state_d = S_T6;
                        default:                    state_d = S_T0;
                    endcase
                end
                S_T6: begin
                    case (cls)
                        CLS_LD:  state_d = mem_rdy ? S_T7 : S_T6;
                        CLS_ST:  state_d = S_T7;
                        default: state_d = S_T0;
                    endcase
                end
                S_T7: begin
                    if (cls == CLS_ST) begin
                        state_d = mem_rdy ? S_T0 : S_T7;
                    end else begin
                        state_d = S_T0;
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_T0;
            endcase
        end
    end

    // State register; clr aborts any sequence immediately
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_T0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Moore output decode from the registered state and the stable IR
    always_comb begin
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        Cout     = 1'b0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        BAout    = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        alu_op   = 5'b00000;
        illegal  = 1'b0;
        run      = run_q && (state_q != S_HALT);
        if (run_q) begin
            case (state_q)
                S_T0: begin
                    PCout = 1'b1;
                    MARin = 1'b1;
                    IncPC = 1'b1;
                    Zin   = 1'b1;
                end
                S_T1: begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                    Read    = 1'b1;
                    MDRin   = 1'b1;
                end
                S_T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                S_T3: begin
                    case (cls)
                        CLS_RTYPE, CLS_IMM: begin
                            Grb  = 1'b1;
                            Rout = 1'b1;
                            Yin  = 1'b1;
                        end
                        CLS_LDI, CLS_LD, CLS_ST: begin
                            Grb   = 1'b1;
                            BAout = 1'b1;
                            Yin   = 1'b1;
                        end
                        CLS_MULDIV: begin
                            Gra  = 1'b1;
                            Rout = 1'b1;
                            Yin  = 1'b1;
                        end
                        CLS_UNARY: begin
                            Grb    = 1'b1;
                            Rout   = 1'b1;
                            alu_op = opcode;
                            Zin    = 1'b1;
                        end
                        CLS_ILLEGAL: illegal = 1'b1;
                        default: ;
                    endcase
                end
                S_T4: begin
                    case (cls)
                        CLS_RTYPE: begin
                            Grc    = 1'b1;
                            Rout   = 1'b1;
                            alu_op = opcode;
                            Zin    = 1'b1;
                        end
                        CLS_IMM: begin
                            Cout   = 1'b1;
                            alu_op = opcode;
                            Zin    = 1'b1;
                        end
                        CLS_LDI, CLS_LD, CLS_ST: begin
                            Cout   = 1'b1;
                            alu_op = ADD_OP;
                            Zin    = 1'b1;
                        end
                        CLS_MULDIV: begin
                            Grb    = 1'b1;
                            Rout   = 1'b1;
                            alu_op = opcode;
                            Zin    = 1'b1;
                        end
                        CLS_UNARY: begin
                            Zlowout = 1'b1;
                            Gra     = 1'b1;
                            Rin     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (cls)
                        CLS_RTYPE, CLS_IMM, CLS_LDI: begin
                            Zlowout = 1'b1;
                            Gra     = 1'b1;
                            Rin     = 1'b1;
                        end
                        CLS_LD, CLS_ST: begin
                            Zlowout = 1'b1;
                            MARin   = 1'b1;
                        end
                        CLS_MULDIV: begin
                            Zlowout = 1'b1;
                            LOin    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (cls)
                        CLS_LD: begin
                            Read  = 1'b1;
                            MDRin = 1'b1;
                        end
                        CLS_ST: begin
                            Gra   = 1'b1;
                            Rout  = 1'b1;
                            MDRin = 1'b1;
                        end
                        CLS_MULDIV: begin
                            Zhighout = 1'b1;
                            HIin     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T7: begin
                    case (cls)
                        CLS_LD: begin
                            MDRout = 1'b1;
                            Gra    = 1'b1;
                            Rin    = 1'b1;
                        end
                        CLS_ST:  Write = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a driver issues per-cycle inputs and pushes the
// expected output vector from a table-level model; a monitor pops and
// compares on every falling edge.
module tb_control_unit;

    localparam int W = 29;

    // Expected-vector bit positions (alu_op in [28:24])
    localparam logic [W-1:0] B_PCOUT    = 29'h1 << 0;
    localparam logic [W-1:0] B_ZHIGHOUT = 29'h1 << 1;
    localparam logic [W-1:0] B_ZLOWOUT  = 29'h1 << 2;
    localparam logic [W-1:0] B_MDROUT   = 29'h1 << 3;
    localparam logic [W-1:0] B_COUT     = 29'h1 << 4;
    localparam logic [W-1:0] B_PCIN     = 29'h1 << 5;
    localparam logic [W-1:0] B_IRIN     = 29'h1 << 6;
    localparam logic [W-1:0] B_MARIN    = 29'h1 << 7;
    localparam logic [W-1:0] B_MDRIN    = 29'h1 << 8;
    localparam logic [W-1:0] B_YIN      = 29'h1 << 9;
    localparam logic [W-1:0] B_ZIN      = 29'h1 << 10;
    localparam logic [W-1:0] B_HIIN     = 29'h1 << 11;
    localparam logic [W-1:0] B_LOIN     = 29'h1 << 12;
    localparam logic [W-1:0] B_INCPC    = 29'h1 << 13;
    localparam logic [W-1:0] B_GRA      = 29'h1 << 14;
    localparam logic [W-1:0] B_GRB      = 29'h1 << 15;
    localparam logic [W-1:0] B_GRC      = 29'h1 << 16;
    localparam logic [W-1:0] B_RIN      = 29'h1 << 17;
    localparam logic [W-1:0] B_ROUT     = 29'h1 << 18;
    localparam logic [W-1:0] B_BAOUT    = 29'h1 << 19;
    localparam logic [W-1:0] B_READ     = 29'h1 << 20;
    localparam logic [W-1:0] B_WRITE    = 29'h1 << 21;
    localparam logic [W-1:0] B_RUN      = 29'h1 << 22;
    localparam logic [W-1:0] B_ILLEGAL  = 29'h1 << 23;
    localparam logic [W-1:0] ZERO       = 29'h0;

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic        mem_rdy;
    logic        PCout, Zhighout, Zlowout, MDRout, Cout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        Read, Write;
    logic [4:0]  alu_op;
    logic        run, illegal;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    bit           done   = 0;

    control_unit #(.ADD_OP(5'b00011)) dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_rdy(mem_rdy),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MDRout(MDRout), .Cout(Cout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Read(Read), .Write(Write),
        .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] pack_outputs();
        return {alu_op, illegal, run, Write, Read, BAout, Rout, Rin, Grc,
                Grb, Gra, IncPC, LOin, HIin, Zin, Yin, MDRin, MARin, IRin,
                PCin, Cout, MDRout, Zlowout, Zhighout, PCout};
    endfunction

    function automatic logic [W-1:0] alu(input logic [4:0] op);
        return {op, 24'h0};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: one expected vector per cycle, compared mid-cycle
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        string        t;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = pack_outputs();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s cycle %0d got=%h expected=%h", t, cyc, a, e);
                end
            end
        end
    end

    // Driver step: set inputs just after the edge, queue the expectation
    task automatic cycle(input logic [W-1:0] e, input logic rdy, input string tag);
        mem_rdy = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic hold_zero(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(ZERO, rnd_bit(), tag);
    endtask

    task automatic wait_state(input logic [W-1:0] e, input int waits, input string tag);
        for (int i = 0; i < waits; i++) cycle(e, 1'b0, tag);
        cycle(e, 1'b1, tag);
    endtask

    // Reference model: fetch, then the class sequence straight from the opcode table
    task automatic run_instr(input logic [31:0] ir_val, input int fw, input int mw,
                             input bit abort_st);
        logic [4:0]   opc;
        logic [W-1:0] dst_write;
        opc = ir_val[31:27];
        dst_write = B_RUN | B_ZLOWOUT | B_GRA | B_RIN;
        ir = $urandom;
        cycle(B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZIN, rnd_bit(), "fetch_t0");
        wait_state(B_RUN | B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN, fw, "fetch_t1");
        ir = ir_val;
        cycle(B_RUN | B_MDROUT | B_IRIN, rnd_bit(), "fetch_t2");
        if (opc >= 5'd3 && opc <= 5'd10) begin
            cycle(B_RUN | B_GRB | B_ROUT | B_YIN, rnd_bit(), "rtype_t3");
            cycle(B_RUN | B_GRC | B_ROUT | B_ZIN | alu(opc), rnd_bit(), "rtype_t4");
            cycle(dst_write, rnd_bit(), "rtype_t5");
        end else if (opc >= 5'd11 && opc <= 5'd13) begin
            cycle(B_RUN | B_GRB | B_ROUT | B_YIN, rnd_bit(), "imm_t3");
            cycle(B_RUN | B_COUT | B_ZIN | alu(opc), rnd_bit(), "imm_t4");
            cycle(dst_write, rnd_bit(), "imm_t5");
        end else if (opc <= 5'd2) begin
            cycle(B_RUN | B_GRB | B_BAOUT | B_YIN, rnd_bit(), "addr_t3");
            cycle(B_RUN | B_COUT | B_ZIN | alu(5'b00011), rnd_bit(), "addr_t4");
            if (opc == 5'd1) begin
                cycle(dst_write, rnd_bit(), "ldi_t5");
            end else if (opc == 5'd0) begin
                cycle(B_RUN | B_ZLOWOUT | B_MARIN, rnd_bit(), "ld_t5");
                wait_state(B_RUN | B_READ | B_MDRIN, mw, "ld_t6");
                cycle(B_RUN | B_MDROUT | B_GRA | B_RIN, rnd_bit(), "ld_t7");
            end else begin
                cycle(B_RUN | B_ZLOWOUT | B_MARIN, rnd_bit(), "st_t5");
                cycle(B_RUN | B_GRA | B_ROUT | B_MDRIN, rnd_bit(), "st_t6");
                if (abort_st) begin
                    cycle(B_RUN | B_WRITE, 1'b0, "st_t7");
                    mem_rdy = 1'b0;
                    exp_q.push_back(ZERO);
                    tag_q.push_back("abort");
                    #1 clr = 1'b0;
                    #1;
                    checks++;
                    if (Write !== 1'b0 || run !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_async got Write=%b run=%b expected 0 0", Write, run);
                    end
                    @(posedge clk);
                    #1;
                    hold_zero(1, "abort_rst");
                    clr = 1'b1;
                    hold_zero(1, "abort_release");
                end else begin
                    wait_state(B_RUN | B_WRITE, mw, "st_t7");
                end
            end
        end else if (opc == 5'd14 || opc == 5'd15) begin
            cycle(B_RUN | B_GRA | B_ROUT | B_YIN, rnd_bit(), "muldiv_t3");
            cycle(B_RUN | B_GRB | B_ROUT | B_ZIN | alu(opc), rnd_bit(), "muldiv_t4");
            cycle(B_RUN | B_ZLOWOUT | B_LOIN, rnd_bit(), "muldiv_t5");
            cycle(B_RUN | B_ZHIGHOUT | B_HIIN, rnd_bit(), "muldiv_t6");
        end else if (opc == 5'd16 || opc == 5'd17) begin
            cycle(B_RUN | B_GRB | B_ROUT | B_ZIN | alu(opc), rnd_bit(), "unary_t3");
            cycle(dst_write, rnd_bit(), "unary_t4");
        end else if (opc == 5'd26) begin
            cycle(B_RUN, rnd_bit(), "nop_t3");
        end else if (opc == 5'd27) begin
            cycle(B_RUN, rnd_bit(), "halt_t3");
        end else begin
            cycle(B_RUN | B_ILLEGAL, rnd_bit(), "illegal_t3");
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] opc);
        logic [31:0] r;
        r = $urandom;
        r[31:27] = opc;
        return r;
    endfunction

    // Main stimulus sequence
    initial begin
        logic [4:0] opc;
        clr = 1'b0;
        ir = 32'h0;
        mem_rdy = 1'b0;
        @(posedge clk);
        #1;
        hold_zero(2, "reset");
        clr = 1'b1;
        hold_zero(1, "release");

        run_instr(32'h18C40000, 3, 0, 0);
        run_instr(mk(5'b00100), 0, 0, 0);
        run_instr(mk(5'b00000), 1, 2, 0);
        run_instr(mk(5'b00010), 0, 1, 0);
        run_instr(mk(5'b01110), 0, 0, 0);
        run_instr(mk(5'b01111), 2, 0, 0);
        run_instr(mk(5'b10000), 0, 0, 0);
        run_instr(mk(5'b10001), 0, 0, 0);
        run_instr(mk(5'b01011), 0, 0, 0);
        run_instr(mk(5'b00001), 0, 0, 0);
        run_instr(mk(5'b11010), 0, 0, 0);
        run_instr(mk(5'b11111), 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            opc = 5'($urandom_range(0, 31));
            if (opc == 5'b11011) opc = 5'b11010;
            run_instr(mk(opc), $urandom_range(0, 2), $urandom_range(0, 3), 0);
        end

        run_instr(mk(5'b00010), 0, 0, 1);
        run_instr(mk(5'b00001), 1, 0, 0);

        run_instr(mk(5'b11011), 0, 0, 0);
        hold_zero(20, "halted");

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog bound on the whole run
    initial begin
        #200000;
        if (!done) begin
            errors++;
            $display("FAIL timeout got=running expected=finished");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencing control unit for the phase-2 CPU. Consumes the instruction register contents and a memory-ready handshake, and drives the datapath's register-enable, bus-select, ALU-opcode and memory-strobe signals. Each instruction runs as a multi-cycle T-state sequence (fetch, then a class-specific execute sequence). Register-number fields are left to the datapath's select-and-encode logic through Gra/Grb/Grc.

## Interface
Parameters:
- ADD_OP, 5'b00011, ALU opcode forced for address/immediate-base calculation.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- ir  in  32  instruction register; opcode = ir[31:27].
- mem_rdy  in  1  memory ready; completes a Read/Write wait state.
- PCout, Zhighout, Zlowout, MDRout, Cout  out  1 each  bus source selects.
- PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC  out  1 each  register load enables.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  general-register field select and direction.
- Read, Write  out  1 each  memory strobes.
- alu_op  out  5  ALU opcode.
- run  out  1  high while executing; low in reset and HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.

## Operation
Opcodes:
- ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, shr=00111, shl=01000, ror=01001, rol=01010.
- addi=01011, andi=01100, ori=01101, mul=01110, div=01111, neg=10000, not=10001, nop=11010, halt=11011.
- All other opcodes are illegal.

States and asserted outputs (unlisted outputs are 0):
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin. Held while mem_rdy=0.
- T2: MDRout, IRin.
- T3 onward: decode ir[31:27] and run the class sequence below. After the last step, return to T0.

Class sequences:
- R-type (add..rol): T3 Grb,Rout,Yin | T4 Grc,Rout,alu_op=opcode,Zin | T5 Zlowout,Gra,Rin.
- Immediate (addi/andi/ori): T3 Grb,Rout,Yin | T4 Cout,alu_op=opcode,Zin | T5 Zlowout,Gra,Rin.
- ldi: T3 Grb,BAout,Yin | T4 Cout,alu_op=ADD_OP,Zin | T5 Zlowout,Gra,Rin.
- ld: as ldi through T4 | T5 Zlowout,MARin | T6 Read,MDRin (held until mem_rdy) | T7 MDRout,Gra,Rin.
- st: as ldi through T4 | T5 Zlowout,MARin | T6 Gra,Rout,MDRin | T7 Write (held until mem_rdy).
- mul/div: T3 Gra,Rout,Yin | T4 Grb,Rout,alu_op=opcode,Zin | T5 Zlowout,LOin | T6 Zhighout,HIin.
- neg/not: T3 Grb,Rout,alu_op=opcode,Zin | T4 Zlowout,Gra,Rin.
- nop: T3 only, with no outputs asserted.
- halt: go to HALT. HALT holds every output at 0 and run=0; only clr exits it.
- illegal: pulse illegal in T3 and behave as nop.

alu_op is 0 in every state not listed above.

## Timing
- Reset: clr low forces state=T0 asynchronously, with all outputs 0, including run. On the first clk edge after clr rises, run=1 and T0 outputs are active.
- Each state lasts one cycle, except wait states T1 (fetch), ld T6 and st T7.
- Wait states: strobes and enables stay asserted every cycle while mem_rdy=0. The state advances on the rising edge where mem_rdy=1. MDRin and Read are both high on that edge, so the MDR captures the memory data.
- With mem_rdy tied high:
  - R-type/immediate/ldi: 6 cycles.
  - mul/div: 7 cycles.
  - ld/st: 8 cycles.
  - neg/not: 5 cycles.
  - nop: 4 cycles.
- Outputs are decoded from the registered state and ir (Moore-style), glitch-free relative to clk.
- ir is sampled during T3..T7. ir is stable because IRin asserts only in T2.
- clr asserted mid-instruction, including during a wait state, aborts immediately. All strobes drop in the same cycle.

## Structure
- A shared package cpu_pkg holds:
  - opcode localparams;
  - the state enumeration (T0..T7, HALT);
  - IR field bounds: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0].
- One combinational sub-module, instr_class, maps the opcode to its class (RTYPE, IMM, LDI, LD, ST, MULDIV, UNARY, NOP, HALT, ILLEGAL). The FSM branches on this class.

## Test plan
- Reset then fetch, mem_rdy=1:
  - clr low gives all outputs 0.
  - After release: T0 asserts PCout,MARin,IncPC,Zin; T1 asserts Read,MDRin,PCin; T2 asserts IRin.
- Fetch wait: mem_rdy=0 for 3 cycles in T1, then 1.
  - Read/MDRin are high for 4 consecutive cycles.
  - IRin is high in the next cycle.
- add (ir=32'h18C40000) and sub (ir[31:27]=00100):
  - T4 shows alu_op=00011 and 00100 respectively, with Grc,Rout,Zin.
  - T5 shows Zlowout,Gra,Rin.
  - Each instruction is 6 cycles total.
- ld with mem_rdy delayed 2 cycles at T6:
  - alu_op=00011 in T4.
  - Read held 3 cycles.
  - T7 shows MDRout,Gra,Rin.
  - st asserts Write in T7 and Gra,Rout,MDRin in T6.
- mul:
  - T5 shows Zlowout,LOin; T6 shows Zhighout,HIin.
  - Next cycle is T0.
- Boundary cases:
  - Opcode 11111: illegal pulses for exactly 1 cycle, then T0.
  - halt: run drops and all outputs stay 0 for 20 cycles.
  - clr pulse mid st-T7: Write drops asynchronously, and fetch restarts after release.
